// File: rtl/gpu_pkg.sv
// Shared GPU types and constants: framebuffer geometry, 640x480@60 VGA
// timing defaults and the 3-3-2 to 4-4-4 color expansion.
package gpu_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_ADDR_W = 17;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    // Counter width covers 800 columns and 525 lines.
    localparam int CNT_W = 10;

    // Sync strobes travelling down the output pipeline (active high inside).
    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_t;

    // RRRGGGBB -> {R4,G4,B4}; MSBs are replicated into the new LSBs so
    // full-scale inputs map to full-scale outputs.
    function automatic logic [11:0] expand332(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with sync, visible and vblank decode.
// All decode outputs are combinational from the counter registers.
module vga_timing_gen
    import gpu_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             visible,
    output logic             hsync,
    output logic             vsync,
    output logic             vblank,
    output logic             line_end,
    output logic             frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    assign line_end  = (hcount == H_LAST);
    assign frame_end = line_end && (vcount == V_LAST);

    // Column counter wraps each line; line counter steps on the column wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (line_end) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    assign visible = (hcount < H_VIS) && (vcount < V_VIS);
    assign hsync   = (hcount >= HS_BEG) && (hcount <= HS_END);
    assign vsync   = (vcount >= VS_BEG) && (vcount <= VS_END);
    assign vblank  = (vcount >= V_VIS);

endmodule

// File: rtl/frame_scanout.sv
// Display-side framebuffer reader: 2x2 pixel replication from a 320x240
// 8-bit bank, 3-3-2 color expansion, sync/DE alignment with rgb, and
// front/back bank swapping at vblank entry.
// Pipeline: counters -> registered address/enable -> registered rgb/de/sync.
// fb_rd_data is sampled on the edge after the address register updates.
module frame_scanout
    import gpu_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [FB_ADDR_W-1:0] fb_rd_addr,
    output logic                 fb_rd_en,
    input  logic [7:0]           fb_rd_data,
    output logic                 front_buf,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 hsync_n,
    output logic                 vsync_n,
    output logic                 de,
    output logic [11:0]          rgb,
    output logic                 vblank
);

    localparam int STAGES = 2;
    localparam logic [CNT_W-1:0]     V_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [FB_ADDR_W-1:0] ROW_STRIDE = FB_ADDR_W'(FB_WIDTH);

    logic [CNT_W-1:0]     hcount;
    logic [CNT_W-1:0]     vcount;
    logic                 visible;
    logic                 line_end;
    logic                 frame_end;
    logic                 vblank_entry;
    sync_t                sync_now;
    sync_t [STAGES:1]     sync_pipe;
    logic  [STAGES:1]     vld_pipe;
    logic [FB_ADDR_W-1:0] row_base;
    logic [FB_ADDR_W-1:0] pix_addr;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_tmg (
        .clk       (clk),
        .rst       (rst),
        .hcount    (hcount),
        .vcount    (vcount),
        .visible   (visible),
        .hsync     (sync_now.hsync),
        .vsync     (sync_now.vsync),
        .vblank    (vblank),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    assign vblank_entry = (hcount == '0) && (vcount == V_VIS);

    // Horizontal 2x replication: drop the column LSB.
    assign pix_addr = row_base + FB_ADDR_W'(hcount >> 1);

    // Row base advances one framebuffer row after every second visible line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_base <= '0;
        end else if (frame_end) begin
            row_base <= '0;
        end else if (line_end && vcount[0] && (vcount < V_VIS)) begin
            row_base <= row_base + ROW_STRIDE;
        end
    end

    // Bank swap only at vblank entry, so a frame is always read from one bank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            front_buf <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= vblank_entry && swap_req;
            if (vblank_entry && swap_req) begin
                front_buf <= ~front_buf;
            end
        end
    end

    // Output pipeline: stage 1 address/enable, stage 2 rgb and delayed syncs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fb_rd_addr <= '0;
            vld_pipe   <= '0;
            sync_pipe  <= '0;
            rgb        <= '0;
        end else begin
            if (visible) begin
                fb_rd_addr <= pix_addr;
            end
            vld_pipe[1]  <= visible;
            vld_pipe[2]  <= vld_pipe[1];
            sync_pipe[1] <= sync_now;
            sync_pipe[2] <= sync_pipe[1];
            rgb          <= vld_pipe[1] ? expand332(fb_rd_data) : '0;
        end
    end

    assign fb_rd_en = vld_pipe[1];
    assign de       = vld_pipe[STAGES];
    assign hsync_n  = ~sync_pipe[STAGES].hsync;
    assign vsync_n  = ~sync_pipe[STAGES].vsync;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout. Horizontal timing is the real 640-wide line; the
// vertical geometry is shortened to 6 visible lines (9 total) so that several
// vblank entries fit in a short run.
module tb_frame_scanout;

    localparam int HV = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VV = 6, VFP = 1, VS = 1, VBP = 1;
    localparam int H_TOT = HV + HFP + HS + HBP;
    localparam int V_TOT = VV + VFP + VS + VBP;
    localparam int WAIT_LIMIT = 2 * H_TOT * V_TOT;

    typedef struct packed {
        logic        hs_n;
        logic        vs_n;
        logic        de;
        logic [11:0] rgb;
    } px_t;

    typedef struct {
        int          h;
        int          v;
        logic        chk_addr;
        logic [16:0] addr;
        logic        en;
        logic        chk_pix;
        logic        de;
        logic [11:0] rgb;
    } vec_t;

    localparam px_t IDLE = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0, rgb: 12'h000};

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] fb_rd_addr;
    logic        fb_rd_en;
    logic [7:0]  fb_rd_data;
    logic        front_buf;
    logic        swap_req;
    logic        swap_ack;
    logic        hsync_n;
    logic        vsync_n;
    logic        de;
    logic [11:0] rgb;
    logic        vblank;

    logic [7:0]  mem [0:2047];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;

    // Model state, written only by the scoreboard process.
    int          mh = 0, mv = 0;
    logic [16:0] m_addr = '0;
    logic        m_en = 1'b0, m_fb = 1'b0, m_ack = 1'b0;
    px_t         exp_q[$];
    vec_t        vecs[$];

    always #20 clk = ~clk;

    assign fb_rd_data = mem[fb_rd_addr[10:0]];

    frame_scanout #(
        .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fb_rd_addr (fb_rd_addr),
        .fb_rd_en   (fb_rd_en),
        .fb_rd_data (fb_rd_data),
        .front_buf  (front_buf),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .de         (de),
        .rgb        (rgb),
        .vblank     (vblank)
    );

    function automatic logic [11:0] exp12(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    function automatic logic [16:0] pix_addr(input int h, input int v);
        return 17'((v / 2) * 320 + h / 2);
    endfunction

    // Expected stage-2 outputs for counter position (h,v).
    function automatic px_t mk_px(input int h, input int v);
        px_t p;
        p.de   = (h < HV) && (v < VV);
        p.hs_n = !((h >= HV + HFP) && (h < HV + HFP + HS));
        p.vs_n = !((v >= VV + VFP) && (v < VV + VFP + VS));
        p.rgb  = p.de ? exp12(mem[pix_addr(h, v)]) : 12'h000;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pos(input int h, input int v, input string nm);
        int k;
        for (k = 0; k < WAIT_LIMIT; k++) begin
            if (mh == h && mv == v) break;
            step();
        end
        if (k == WAIT_LIMIT) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: timed out waiting for (%0d,%0d), got (%0d,%0d)", nm, h, v, mh, mv);
        end
    endtask

    task automatic add_vec(input int h, input int v, input logic ca, input logic [16:0] a,
                           input logic en, input logic cp, input logic d, input logic [11:0] c);
        vec_t t;
        t.h = h; t.v = v; t.chk_addr = ca; t.addr = a; t.en = en;
        t.chk_pix = cp; t.de = d; t.rgb = c;
        vecs.push_back(t);
    endtask

    // Scoreboard: each cycle the record for the current counter position is
    // queued; it is popped two edges later, when it reaches the rgb stage.
    initial begin : scoreboard
        px_t         exp_px;
        logic [35:0] act, expv;
        int          ph, pv;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                mh = 0; mv = 0; m_addr = '0; m_en = 1'b0; m_fb = 1'b0; m_ack = 1'b0;
                exp_q.delete();
                exp_px = IDLE;
                exp_q.push_back(IDLE);
                exp_q.push_back(mk_px(0, 0));
            end else begin
                ph = mh; pv = mv;
                m_ack = (ph == 0) && (pv == VV) && swap_req;
                if (m_ack) m_fb = ~m_fb;
                m_en = (ph < HV) && (pv < VV);
                if (m_en) m_addr = pix_addr(ph, pv);
                if (ph == H_TOT - 1) begin
                    mh = 0;
                    mv = (pv == V_TOT - 1) ? 0 : pv + 1;
                end else begin
                    mh = ph + 1;
                end
                exp_px = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE;
                exp_q.push_back(mk_px(mh, mv));
            end
            expv = {m_addr, m_en, m_fb, m_ack, (mv >= VV) ? 1'b1 : 1'b0, exp_px};
            act  = {fb_rd_addr, fb_rd_en, front_buf, swap_ack, vblank, hsync_n, vsync_n, de, rgb};
            chk($sformatf("scoreboard cycle %0d", cyc), act, expv);
        end
    end

    initial begin : main
        int n_run;
        rst = 1'b0;
        swap_req = 1'b0;
        for (int a = 0; a < 2048; a++) mem[a] = 8'(a * 37 + 11);
        mem[5] = 8'hE3;
        mem[6] = 8'h49;

        // Each row is sampled with the counters at (h,v): fb_rd_addr/fb_rd_en
        // reflect position h-1, rgb/de reflect position h-2.
        add_vec(1,   0, 1, 17'd0,   1, 0, 0, 12'h000);
        add_vec(2,   0, 1, 17'd0,   1, 0, 0, 12'h000);
        add_vec(3,   0, 1, 17'd1,   1, 0, 0, 12'h000);
        add_vec(4,   0, 1, 17'd1,   1, 0, 0, 12'h000);
        add_vec(12,  0, 1, 17'd5,   1, 1, 1, 12'hF0F);
        add_vec(14,  0, 1, 17'd6,   1, 1, 1, 12'h445);
        add_vec(641, 0, 1, 17'd319, 0, 1, 1, exp12(mem[319]));
        add_vec(702, 0, 1, 17'd319, 0, 1, 0, 12'h000);
        add_vec(0,   1, 1, 17'd319, 0, 1, 0, 12'h000);
        add_vec(1,   1, 1, 17'd0,   1, 1, 0, 12'h000);
        add_vec(12,  1, 1, 17'd5,   1, 1, 1, 12'hF0F);
        add_vec(1,   2, 1, 17'd320, 1, 0, 0, 12'h000);
        add_vec(2,   2, 1, 17'd320, 1, 1, 1, exp12(mem[320]));
        add_vec(640, 5, 1, 17'd959, 1, 1, 1, exp12(mem[959]));
        add_vec(641, 5, 1, 17'd959, 0, 1, 1, exp12(mem[959]));

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        n_run = $urandom_range(400, 3000);
        repeat (n_run) step();

        // Reset from an arbitrary raster position.
        rst = 1'b0;
        repeat (3) step();
        chk("reset fb_rd_addr", 36'(fb_rd_addr), 36'd0);
        chk("reset fb_rd_en",   36'(fb_rd_en),   36'd0);
        chk("reset front_buf",  36'(front_buf),  36'd0);
        chk("reset swap_ack",   36'(swap_ack),   36'd0);
        chk("reset hsync_n",    36'(hsync_n),    36'd1);
        chk("reset vsync_n",    36'(vsync_n),    36'd1);
        chk("reset de",         36'(de),         36'd0);
        chk("reset rgb",        36'(rgb),        36'd0);
        chk("reset vblank",     36'(vblank),     36'd0);
        rst = 1'b1;

        fork
            begin : hsync_check
                int hs_first, hs_len;
                hs_first = -1;
                hs_len = 0;
                for (int e = 1; e <= 800; e++) begin
                    step();
                    if (hsync_n == 1'b0) begin
                        if (hs_first < 0) hs_first = e;
                        hs_len++;
                    end
                end
                chk("first hsync_n low edge", 36'(hs_first), 36'd658);
                chk("hsync_n low length",     36'(hs_len),   36'd96);
            end
            begin : vector_loop
                foreach (vecs[i]) begin
                    wait_pos(vecs[i].h, vecs[i].v, $sformatf("vec%0d position", i));
                    if (vecs[i].chk_addr) begin
                        chk($sformatf("vec%0d fb_rd_addr", i), 36'(fb_rd_addr), 36'(vecs[i].addr));
                        chk($sformatf("vec%0d fb_rd_en", i),   36'(fb_rd_en),   36'(vecs[i].en));
                    end
                    if (vecs[i].chk_pix) begin
                        chk($sformatf("vec%0d de", i),  36'(de),  36'(vecs[i].de));
                        chk($sformatf("vec%0d rgb", i), 36'(rgb), 36'(vecs[i].rgb));
                    end
                end
            end
        join

        // Request mid-frame: held off until vblank entry, then one swap.
        wait_pos(0, 3, "swapA req");
        swap_req = 1'b1;
        wait_pos(0, VV, "swapA entry");
        chk("swapA front before", 36'(front_buf), 36'd0);
        chk("swapA ack before",   36'(swap_ack),  36'd0);
        step();
        chk("swapA front after",  36'(front_buf), 36'd1);
        chk("swapA ack pulse",    36'(swap_ack),  36'd1);
        swap_req = 1'b0;
        step();
        chk("swapA ack single",   36'(swap_ack),  36'd0);

        // No request: no toggle.
        wait_pos(0, VV, "noswap entry");
        step();
        chk("noswap front", 36'(front_buf), 36'd1);
        chk("noswap ack",   36'(swap_ack),  36'd0);

        // Request rising on the entry cycle itself, then held for a frame.
        wait_pos(0, VV, "swapC entry");
        swap_req = 1'b1;
        step();
        chk("swapC front", 36'(front_buf), 36'd0);
        chk("swapC ack",   36'(swap_ack),  36'd1);
        step();
        chk("swapC ack single", 36'(swap_ack), 36'd0);
        wait_pos(0, VV, "swapD entry");
        chk("swapD front before", 36'(front_buf), 36'd0);
        step();
        chk("swapD front", 36'(front_buf), 36'd1);
        chk("swapD ack",   36'(swap_ack),  36'd1);
        swap_req = 1'b0;

        // Mid-frame reset with the second bank in front.
        wait_pos(0, 3, "midreset pos");
        chk("midreset front before", 36'(front_buf), 36'd1);
        rst = 1'b0;
        repeat (2) step();
        chk("midreset front",  36'(front_buf),  36'd0);
        chk("midreset addr",   36'(fb_rd_addr), 36'd0);
        chk("midreset vblank", 36'(vblank),     36'd0);
        rst = 1'b1;
        step();
        chk("restart addr px0", 36'(fb_rd_addr), 36'd0);
        chk("restart en px0",   36'(fb_rd_en),   36'd1);
        repeat (2) step();
        chk("restart addr px2", 36'(fb_rd_addr), 36'd1);
        wait_pos(1, 2, "restart row2");
        chk("restart addr row2", 36'(fb_rd_addr), 36'd320);

        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_scanout.md
# frame_scanout

Display-side reader of the double-buffered 320x240 8-bit frame buffer that the rasterizer writes. It generates 640x480@60 VGA timing, fetches each framebuffer pixel with 2x horizontal and vertical replication, expands 3-3-2 color to 12-bit RGB and drives sync/DE outputs. It also owns the front/back buffer select and performs rasterizer-requested buffer swaps at vblank entry.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  pixel clock (25 MHz); the only clock
- rst  in  1  synchronous, active-low reset
- fb_rd_addr  out  17  framebuffer read address, y*320+x
- fb_rd_en  out  1  read enable, high only for visible pixels
- fb_rd_data  in  8  BRAM read data, valid 1 cycle after address
- front_buf  out  1  bank being scanned out; rasterizer writes the other bank
- swap_req  in  1  level request from the rasterizer side: back buffer complete
- swap_ack  out  1  one-cycle pulse: swap performed
- hsync_n  out  1  active-low hsync
- vsync_n  out  1  active-low vsync
- de  out  1  display enable, aligned with rgb
- rgb  out  12  {R4,G4,B4}, zero when de low
- vblank  out  1  high while vcount >= V_VISIBLE (undelayed)

## Operation
- hcount counts 0..799 and wraps. vcount advances on the hcount wrap, counts 0..524 and wraps.
- Visible region is hcount<640 && vcount<480.
- hsync active for hcount in [656,751]. vsync active for vcount in [490,491].
- Addressing is incremental, with no multiplier:
  - row_base is cleared at vcount wrap and increases by 320 at the end of each odd visible line.
  - fb_rd_addr = row_base + hcount[9:1], registered.
  - Bounds: address 0 at (0,0), 76799 at (639,479). fb_rd_addr holds its last value while blanked.
- Color expansion from d=RRRGGGBB: R={d[7:5],d[7]}, G={d[4:2],d[4]}, B={d[1:0],d[1:0]}.
- Swap:
  - Sampled only on the vblank-entry cycle (hcount==0, vcount==480).
  - If swap_req is high on that cycle, front_buf toggles and swap_ack pulses on the same edge.
  - A request raised on that exact cycle is honored. A request raised at any other time waits for the next vblank entry.
  - If swap_req is still high at the following vblank entry, another swap occurs. The requester drops swap_req on swap_ack.
- Reset (any time, including mid-frame): hcount=0, vcount=0, row_base=0, front_buf=0. The frame restarts from the top-left.

## Timing
- Reset values: fb_rd_addr=0, fb_rd_en=0, front_buf=0, swap_ack=0, hsync_n=1, vsync_n=1, de=0, rgb=0, vblank=0.
- Pipeline:
  - Stage 0: counters.
  - Stage 1: registered address and read enable.
  - Stage 2: BRAM data valid; rgb/de registered from it.
- hsync_n, vsync_n and de are delayed 2 cycles from counter decode so they align with rgb.
- Total latency from counter state to rgb is 2 cycles. vblank is not delayed.
- Frame is 800*525 = 420000 cycles. Each framebuffer pixel is shown for 2 consecutive cycles on 2 consecutive lines.
- front_buf changes only on vblank-entry edges, so no visible pixel is ever fetched from a bank mid-swap.

## Structure
- Shared package gpu_pkg:
  - FB_WIDTH=320, FB_HEIGHT=240, FB_ADDR_W=17.
  - VGA timing constants, used as parameter defaults.
  - Function expand332 (8 to 12 bit).
- Sub-module vga_timing_gen holds hcount/vcount, the sync decode, visible and vblank.
- frame_scanout holds addressing, the swap logic and the output pipeline.

## Test plan
- Reset: hold rst=0 for 3 cycles at random counter state -> all outputs at reset values. Release -> first hsync_n low at cycle 658 after release, lasting 96 cycles.
- Addressing:
  - Line 0, hcount 0..3 -> fb_rd_addr 0,0,1,1.
  - vcount=1, hcount=0 -> 0. vcount=2, hcount=0 -> 320. (639,479) -> 76799.
  - fb_rd_en=0 for hcount 640..799.
- Color: fb_rd_data=8'hE3 -> rgb=12'hF0F 2 cycles after its address. 8'h49 -> 12'h445. During blanking, de=0 and rgb=0.
- Swap: assert swap_req at vcount=100 -> no change until (hcount 0, vcount 480), then front_buf 0->1 with a single swap_ack pulse. No swap_req -> no toggle.
- Swap boundaries:
  - swap_req rises exactly on the vblank-entry cycle -> swap honored.
  - swap_req held high across two frames -> two swaps: front_buf 0->1->0.
- Mid-frame reset at vcount=300 with front_buf=1 -> front_buf=0 and the counters restart. The next frame's address sequence begins at 0.
